// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle binary-to-BCD converter using shift-and-add-3
// (double dabble), with start/busy/done handshake, sign flag and sticky overflow.
module bin2bcd_seq #(
  parameter int W      = 10,
  parameter int DIGITS = 3,
  parameter int SIGNED = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [W-1:0]        bin,
  output logic                busy,
  output logic                done,
  output logic                neg,
  output logic                ovf,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  localparam logic [0:0]    S_IDLE    = 1'b0;
  localparam logic [0:0]    S_SHIFT   = 1'b1;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [W-1:0]  ONE_W     = W'(1);

  logic [0:0]    state_q,   state_d;
  logic [W-1:0]  mag_q,     mag_d;
  logic [BW-1:0] scratch_q, scratch_d;
  logic          sign_q,    sign_d;
  logic          sticky_q,  sticky_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [BW-1:0] bcd_q,     bcd_d;
  logic          neg_q,     neg_d;
  logic          ovf_q,     ovf_d;
  logic          done_q,    done_d;

  logic [BW-1:0] adjusted;
  logic [BW-1:0] shifted;
  logic          carry_out;

  // Add-3 correction: any digit of 5..9 would reach 10+ once doubled.
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted   = {adjusted[BW-2:0], mag_q[W-1]};
  assign carry_out = adjusted[BW-1];

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d   = state_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    sign_d    = sign_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((SIGNED != 0) && bin[W-1]) begin
            mag_d = ~bin + ONE_W;
          end else begin
            mag_d = bin;
          end
          sign_d    = (SIGNED != 0) && bin[W-1];
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = shifted;
        mag_d     = {mag_q[W-2:0], 1'b0};
        sticky_d  = sticky_q | carry_out;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == LAST_ITER) begin
          bcd_d   = shifted;
          ovf_d   = sticky_q | carry_out;
          neg_d   = sign_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (scratch digits included) is reset so an aborted conversion
  // leaves nothing behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      sign_q    <= 1'b0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      sign_q    <= sign_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = done_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;

endmodule
